// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
//   Memory-mapped 8N1 serial transmitter. The core writes bytes into a small
//   TX FIFO over the data-memory bus; a serialiser drains the FIFO onto tx_o.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   cs           chip select, active-low
//   we           write enable (only meaningful while cs=0)
//   mask[3:0]    byte-lane write mask
//   addr_i       byte address, addr_i[3:2] selects the register
//   wdata_i      write data
//   rdata_o      read data, combinational from addr_i and register state
//   tx_o         serial output, idle high, registered
//   irq_o        high while FIFO empty and serialiser idle
//   dbg_state_o  current serialiser state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Register map (addr_i[3:2])
//   0 TXDATA    write-only, reads 0
//   1 STATUS    [0] busy [1] full [2] empty [3] overflow (write 1 clears)
//               [7:4] fifo count
//   2 BAUD_DIV  [15:0] clocks per bit, 0 behaves as 1
//   3 reserved
//
// Bus handshake: a bus access happens in any cycle with cs=0; writes
// (we=1) commit on the rising clk_i edge, reads are combinational with no
// side effects. There is no wait state and no backpressure.
// ---------------------------------------------------------------------------
module uart_tx_periph #(
    parameter int          DW         = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    mask,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          tx_o,
    output logic          irq_o,
    output logic [1:0]    dbg_state_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Registers
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_baud_div;
    state_t        r_state;
    logic [7:0]    r_shift;
    logic [15:0]   r_period;
    logic [15:0]   r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic          r_tx;

    // Combinational signals
    logic [1:0]    w_reg;
    logic          w_wr_en;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_ovf_clear;
    logic          w_bit_end;
    logic [15:0]   w_div_eff;
    logic [3:0]    w_count4;
    state_t        w_state_next;
    logic [7:0]    w_shift_next;
    logic [15:0]   w_period_next;
    logic [15:0]   w_baud_next;
    logic [2:0]    w_bit_next;
    logic          w_tx_next;
    logic          w_unused_bits;

    assign w_unused_bits = ^{addr_i[DW-1:4], addr_i[1:0], wdata_i[DW-1:16]};

    assign w_reg       = addr_i[3:2];
    assign w_wr_en     = ~cs & we;
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != S_IDLE);
    assign w_push_req  = w_wr_en & (w_reg == 2'd0) & mask[0];
    // A full FIFO still accepts when the serialiser frees a slot this cycle.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & ~w_push;
    assign w_ovf_clear = w_wr_en & (w_reg == 2'd1) & mask[0] & wdata_i[3];
    assign w_div_eff   = (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;
    assign w_bit_end   = (r_baud_cnt == r_period - 16'd1);
    assign w_count4    = 4'(r_count);

    // ---------------------------------------------------------------
    // Serialiser FSM: next-state and datapath updates
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_period_next = r_period;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_cnt;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_next  = r_fifo[r_rd_ptr];
                    w_period_next = w_div_eff;
                    w_baud_next   = 16'd0;
                    w_bit_next    = 3'd0;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = 16'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next  = 16'd0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        // Back-to-back frame: skip IDLE so there is no gap.
                        w_pop         = 1'b1;
                        w_shift_next  = r_fifo[r_rd_ptr];
                        w_period_next = w_div_eff;
                        w_baud_next   = 16'd0;
                        w_bit_next    = 3'd0;
                        w_state_next  = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 16'd1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // tx_o is registered from the next state so it changes on the same
    // edge the FSM enters a bit, with no combinational path to the pin.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'd0;
            r_period   <= 16'd1;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_period   <= w_period_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_tx       <= w_tx_next;
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // ---------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_baud_div <= DIV_RESET;
        end else begin
            // A drop in the same cycle wins over a software clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clear) begin
                r_overflow <= 1'b0;
            end
            if (w_wr_en && (w_reg == 2'd2)) begin
                if (mask[0]) r_baud_div[7:0]  <= wdata_i[7:0];
                if (mask[1]) r_baud_div[15:8] <= wdata_i[15:8];
            end
        end
    end

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    always_comb begin
        rdata_o = '0;
        case (w_reg)
            2'd1: begin
                rdata_o[0]   = w_busy;
                rdata_o[1]   = w_full;
                rdata_o[2]   = w_empty;
                rdata_o[3]   = r_overflow;
                rdata_o[7:4] = w_count4;
            end
            2'd2:    rdata_o[15:0] = r_baud_div;
            default: rdata_o = '0;
        endcase
    end

    assign tx_o        = r_tx;
    assign irq_o       = w_empty & ~w_busy;
    assign dbg_state_o = r_state;

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped serial transmitter.
- Acts as the responder on the core's data-memory bus, using the same cs/we/mask/addr/wdata/rdata signalling as the data memory.
- The core stores bytes into a small TX FIFO. An 8N1 serialiser drains the FIFO onto tx_o.
- Sits beside the data memory in the memory stage; its chip select is driven by the top-level address decode.

Parameters:
DW, 32, bus data/address width
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)
DIV_RESET, 16'd868, reset value of BAUD_DIV (clocks per bit)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
cs  input  1  chip select, active-low (0 = selected)
we  input  1  write enable, sampled only when cs=0
mask  input  4  byte-lane write mask, bit n = byte n
addr_i  input  DW  byte address; only addr_i[3:2] decoded
wdata_i  input  DW  write data
rdata_o  output  DW  read data, combinational from addr_i
tx_o  output  1  serial output, idle high
irq_o  output  1  high while FIFO empty and serialiser idle

Behaviour:
- One clock, clk_i. rst_i is asynchronous, active-high.
- Reset state:
  - tx_o=1, irq_o=1.
  - FIFO empty, FSM IDLE, overflow flag=0.
  - BAUD_DIV=DIV_RESET.
  - rdata_o depends only on addr_i and register state, so it shows reset values.
- Register map (addr_i[3:2]):
  - 0 TXDATA: write-only. Read returns 0.
  - 1 STATUS: read-only except bit 3.
    - [0] busy (FSM != IDLE)
    - [1] fifo_full
    - [2] fifo_empty
    - [3] overflow (sticky)
    - [7:4] fifo count (zero-extended)
    - other bits 0
  - 2 BAUD_DIV: [15:0] read/write. Upper bits read 0.
  - 3 reserved: reads 0, writes ignored.
- Writes take effect on the clk_i rising edge when cs=0 and we=1. Reads are combinational with no side effects.
- TXDATA write:
  - Pushes wdata_i[7:0] only if mask[0]=1. Otherwise ignored.
  - Push accepted if count<FIFO_DEPTH, or if a pop occurs the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- STATUS write: mask[0]=1 and wdata_i[3]=1 clears overflow. A set from a same-cycle drop has priority over the clear.
- BAUD_DIV write:
  - Per-lane: mask[0] updates [7:0], mask[1] updates [15:8].
  - Stored value 0 behaves as 1.
- FIFO: circular, pointer wrap at FIFO_DEPTH. Count is 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, latch BAUD_DIV as the bit period P, reset bit counter → START.
  - START: tx_o=0 for P cycles → DATA.
  - DATA: tx_o=shift[0] for P cycles per bit, LSB first. Shift after each bit. After 8 bits → STOP.
  - STOP: tx_o=1 for P cycles. Then → IDLE, or directly → START with a new pop if the FIFO is non-empty (back-to-back frames, no idle gap).
- Baud counter counts 0..P-1 within each bit and wraps at P-1.
- Frame length is 10*P cycles.
- BAUD_DIV changes mid-frame apply from the next frame only.
- Latency: a TXDATA write at edge N into an empty FIFO with IDLE FSM causes the pop at edge N+1. tx_o falls after edge N+1.
- tx_o is registered (no glitches).
- irq_o = fifo_empty & ~busy, combinational from registers.
- Reset asserted mid-frame: tx_o returns to 1 immediately, FIFO is flushed, and the partial frame is abandoned.

Test Plan:
- Reset, then read STATUS → 0x0000_0004; read BAUD_DIV → 0x0000_0364; tx_o=1, irq_o=1.
- BAUD_DIV=4, write TXDATA=0x0000_00A5 mask=4'b0001 → tx_o low after edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Frame is 40 cycles; busy=1 throughout; irq_o=1 after.
- BAUD_DIV=2, write 5 bytes 0x11..0x15 in consecutive cycles → first pops immediately, remaining 4 fill the FIFO (full=1, overflow=0). Frames are back-to-back with no idle gap; bytes are sent in order.
- BAUD_DIV=8, 6 back-to-back writes → 6th dropped, STATUS[3]=1. STATUS write 0x8 mask=4'b0001 → overflow=0.
- TXDATA write with mask=4'b0010 → no push, count stays 0. BAUD_DIV write 0x0000_1234 mask=4'b0001 → BAUD_DIV reads 0x0000_0334 from reset 0x364.
- Mid-frame (DATA, bit 3), assert rst_i asynchronously → tx_o=1 without waiting for clk_i, STATUS reads 0x4 after release, and no further transitions on tx_o.
